// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard.
// slot_t is one shadow-pipe entry describing an in-flight instruction that may still write a
// register or the NZ flags. The rd field is sized for the largest supported register file and
// narrower register numbers are zero-extended before comparison.
package hazard_pkg;

  // Supports register files of up to 32 entries.
  localparam int unsigned SLOT_RD_W = 5;

  typedef struct packed {
    logic                 valid;
    logic                 rd_en;
    logic [SLOT_RD_W-1:0] rd;
    logic                 is_load;
    logic                 flag_wr;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // Forward-select value meaning "read the register file".
  localparam int unsigned FWD_RF = 0;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder for one source operand.
// Ports:
//   slots_i    - shadow pipe, index 0 = execute (youngest)
//   src_en_i   - source operand is actually read
//   src_i      - source register number
//   idx_o      - index of the youngest slot writing src_i (0 when no match)
//   match_o    - some valid slot writes src_i
//   load_use_o - the youngest match is a load still in slot 0
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned REG_W = 3,
  parameter int unsigned SEL_W = 2
) (
  input  slot_t [DEPTH-1:0] slots_i,
  input  logic              src_en_i,
  input  logic [REG_W-1:0]  src_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              match_o,
  output logic              load_use_o
);

  always_comb begin
    idx_o      = '0;
    match_o    = 1'b0;
    load_use_o = 1'b0;
    // Scan oldest to youngest so the lowest matching index is the one left standing.
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (src_en_i && slots_i[k].valid && slots_i[k].rd_en &&
          slots_i[k].rd == SLOT_RD_W'(src_i)) begin
        match_o = 1'b1;
        idx_o   = SEL_W'(k);
      end
    end
    load_use_o = match_o && (idx_o == '0) && slots_i[0].is_load;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding select for the decode stage.
// Keeps a shadow pipe of issued instructions and decides each cycle whether the decode
// instruction stalls and which stage feeds each source operand.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   dec_*                  - decode-stage instruction fields
//   flush                  - taken branch, kills the decode instruction this cycle
//   stall_out              - hold PC and decode register
//   fwd_a_sel / fwd_b_sel  - 0 = register file, k = result of slot k-1
//   stall_count            - saturating count of stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned FLAG_STAGE = 1,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned REG_W     = $clog2(NUM_REGS),
  localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic             dec_rs_a_en,
  input  logic             dec_rs_b_en,
  input  logic [REG_W-1:0] dec_rs_a,
  input  logic [REG_W-1:0] dec_rs_b,
  input  logic             dec_rd_en,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_is_load,
  input  logic             dec_flag_rd,
  input  logic             dec_flag_wr,
  input  logic             flush,
  output logic             stall_out,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  slot_t [DEPTH-1:0] slot_q, slot_d;
  logic  [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [SEL_W-1:0] idx_a, idx_b;
  logic             match_a, match_b;
  logic             load_use_a, load_use_b;
  logic             hazard_a, hazard_b, hazard_flag;
  logic             issue;

  hazard_match #(
    .DEPTH(DEPTH),
    .REG_W(REG_W),
    .SEL_W(SEL_W)
  ) u_match_a (
    .slots_i   (slot_q),
    .src_en_i  (dec_rs_a_en),
    .src_i     (dec_rs_a),
    .idx_o     (idx_a),
    .match_o   (match_a),
    .load_use_o(load_use_a)
  );

  hazard_match #(
    .DEPTH(DEPTH),
    .REG_W(REG_W),
    .SEL_W(SEL_W)
  ) u_match_b (
    .slots_i   (slot_q),
    .src_en_i  (dec_rs_b_en),
    .src_i     (dec_rs_b),
    .idx_o     (idx_b),
    .match_o   (match_b),
    .load_use_o(load_use_b)
  );

  // NZ is never forwarded, so a pending flag write in the youngest slots always blocks.
  always_comb begin
    hazard_flag = 1'b0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      if (j < int'(FLAG_STAGE) && slot_q[j].valid && slot_q[j].flag_wr) begin
        hazard_flag = dec_flag_rd;
      end
    end
  end

  always_comb begin
    if (FWD_EN != 0) begin
      hazard_a = load_use_a;
      hazard_b = load_use_b;
    end else begin
      hazard_a = match_a;
      hazard_b = match_b;
    end
    stall_out = dec_valid && !flush && (hazard_a || hazard_b || hazard_flag);
    issue     = dec_valid && !stall_out && !flush;

    fwd_a_sel = SEL_W'(FWD_RF);
    fwd_b_sel = SEL_W'(FWD_RF);
    if (FWD_EN != 0 && dec_valid && !stall_out) begin
      if (match_a && !load_use_a) fwd_a_sel = idx_a + SEL_W'(1);
      if (match_b && !load_use_b) fwd_b_sel = idx_b + SEL_W'(1);
    end
  end

  always_comb begin
    slot_d = slot_q;
    for (int i = 1; i < int'(DEPTH); i++) begin
      slot_d[i] = slot_q[i-1];
    end
    // Stalled or flushed cycles push a bubble while older entries keep draining.
    if (issue) begin
      slot_d[0].valid   = 1'b1;
      slot_d[0].rd_en   = dec_rd_en;
      slot_d[0].rd      = SLOT_RD_W'(dec_rd);
      slot_d[0].is_load = dec_is_load;
      slot_d[0].flag_wr = dec_flag_wr;
    end else begin
      slot_d[0] = SLOT_BUBBLE;
    end

    stall_count_d = stall_count_q;
    if (stall_out && stall_count_q != {CNT_W{1'b1}}) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q        <= {DEPTH{SLOT_BUBBLE}};
      stall_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
